// File: rtl/fsk_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsk_decoder_pkg
// Description : Shared definitions for the FSK symbol decoder: phase
//               encoding, symbol-window derivation and minimum-window check.
// Revision    : 1.0 - initial release
// ============================================================================
package fsk_decoder_pkg;

    // Phase encoding of the symbol window sequencer
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DECIDE = 3'd4
    } fsk_state_t;

    // CLEAR + SAMPLE + DECIDE take three cycles; ACCUM needs room left over
    localparam int MIN_WINDOW = 8;

    // Clock cycles per symbol
    function automatic int fsk_window(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

    // True when the symbol window is long enough to hold every phase
    function automatic bit fsk_window_ok(input int window);
        return window >= MIN_WINDOW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_window_timer.sv
`default_nettype none
// ============================================================================
// Module      : fsk_window_timer
// Description : Cuts time into WINDOW-cycle symbol periods:
//               CLEAR(1) / ACCUM(WINDOW-3) / SAMPLE(1) / DECIDE(1).
//               Drives the analyzer enable/clear (registered) and exposes
//               phase strobes to the decision logic.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_window_timer
    import fsk_decoder_pkg::*;
#(
    parameter int WINDOW = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic phase_idle,
    output logic phase_sample,
    output logic phase_decide,
    output logic analyzer_enable,
    output logic analyzer_clear
);

    localparam int ACCUM_LEN = WINDOW - 3;
    localparam int CNT_W     = (ACCUM_LEN > 1) ? $clog2(ACCUM_LEN) : 1;
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCUM_LEN - 1);

    fsk_state_t       state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             analyzer_enable_q, analyzer_enable_d;
    logic             analyzer_clear_q, analyzer_clear_d;

    // Next phase; a low enable pulls back to IDLE from anywhere
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_CLEAR;
                ST_CLEAR: begin
                    state_d   = ST_ACCUM;
                    acc_cnt_d = '0;
                end
                ST_ACCUM: begin
                    if (acc_cnt_q == ACC_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: state_d = ST_DECIDE;
                ST_DECIDE: state_d = ST_CLEAR;
                default:   state_d = ST_IDLE;
            endcase
        end
        // Analyzer controls are decoded from the next phase so they are
        // registered yet line up exactly with the phase they belong to
        analyzer_enable_d = (state_d == ST_ACCUM);
        analyzer_clear_d  = (state_d == ST_CLEAR);
    end

    // Phase register and registered analyzer controls
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            acc_cnt_q         <= '0;
            analyzer_enable_q <= 1'b0;
            analyzer_clear_q  <= 1'b0;
        end else begin
            state_q           <= state_d;
            acc_cnt_q         <= acc_cnt_d;
            analyzer_enable_q <= analyzer_enable_d;
            analyzer_clear_q  <= analyzer_clear_d;
        end
    end

    assign phase_idle      = (state_q == ST_IDLE);
    assign phase_sample    = (state_q == ST_SAMPLE);
    assign phase_decide    = (state_q == ST_DECIDE);
    assign analyzer_enable = analyzer_enable_q;
    assign analyzer_clear  = analyzer_clear_q;

endmodule
`default_nettype wire

// File: rtl/fsk_symbol_decoder.sv
`default_nettype none
// ============================================================================
// Module      : fsk_symbol_decoder
// Description : Decides one FSK bit per symbol window from the frequency
//               analyzer's tone counts, assembles DATA_WIDTH-bit words
//               (LSB first) and offers them on a valid/ready output.
//               Optional feature macro: FSK_DECODER_STATS_EN adds saturating
//               16-bit symbol_count / error_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_symbol_decoder
    import fsk_decoder_pkg::*;
#(
    parameter int CLOCK      = 50000000,
    parameter int BAUD_RATE  = 1000,
    parameter int MIN_COUNT  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [31:0]           f1_value,
    input  logic [31:0]           f2_value,
    output logic                  analyzer_enable,
    output logic                  analyzer_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  symbol_error,
    output logic                  overrun
`ifdef FSK_DECODER_STATS_EN
    ,
    output logic [15:0]           symbol_count,
    output logic [15:0]           error_count
`endif
);

    localparam int WINDOW = fsk_window(CLOCK, BAUD_RATE);
    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_WIDTH - 1);

    generate
        if (!fsk_window_ok(WINDOW) || DATA_WIDTH < 2) begin : g_bad_config
            $error("fsk_symbol_decoder: WINDOW must be >= 8 and DATA_WIDTH >= 2");
        end
    endgenerate

    logic phase_idle, phase_sample, phase_decide;

    fsk_window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .clock           (clock),
        .reset_n         (reset_n),
        .enable          (enable),
        .phase_idle      (phase_idle),
        .phase_sample    (phase_sample),
        .phase_decide    (phase_decide),
        .analyzer_enable (analyzer_enable),
        .analyzer_clear  (analyzer_clear)
    );

    logic [31:0]           f1_cap_q, f1_cap_d, f2_cap_q, f2_cap_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  symbol_error_q, symbol_error_d;
    logic                  overrun_q, overrun_d;
    logic                  bit_one, bit_zero;
    logic [DATA_WIDTH-1:0] new_word;

    // Winner must beat the other tone outright and reach the minimum count
    assign bit_one  = (f2_cap_q > f1_cap_q) && (f2_cap_q >= 32'(MIN_COUNT));
    assign bit_zero = (f1_cap_q > f2_cap_q) && (f1_cap_q >= 32'(MIN_COUNT));
    // New bits enter at the MSB so the first bit ends up in bit 0
    assign new_word = {bit_one, shift_q[DATA_WIDTH-1:1]};

    // Capture, bit decision, word assembly and output handshake
    always_comb begin
        f1_cap_d       = f1_cap_q;
        f2_cap_d       = f2_cap_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_out_d     = data_out_q;
        data_valid_d   = data_valid_q;
        symbol_error_d = 1'b0;
        overrun_d      = overrun_q;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (phase_idle) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            overrun_d = 1'b0;
        end

        if (phase_sample) begin
            f1_cap_d = f1_value;
            f2_cap_d = f2_value;
        end

        if (phase_decide) begin
            if (bit_one || bit_zero) begin
                shift_d = new_word;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    // A pending word may be replaced only if it leaves now
                    if (!data_valid_q || data_ready) begin
                        data_out_d   = new_word;
                        data_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end else begin
                // Undecidable symbol: discard the partial word to resync
                symbol_error_d = 1'b1;
                bit_cnt_d      = '0;
                shift_d        = '0;
            end
        end
    end

    // Decoder state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f1_cap_q       <= '0;
            f2_cap_q       <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            symbol_error_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            f1_cap_q       <= f1_cap_d;
            f2_cap_q       <= f2_cap_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            symbol_error_q <= symbol_error_d;
            overrun_q      <= overrun_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign symbol_error = symbol_error_q;
    assign overrun      = overrun_q;

`ifdef FSK_DECODER_STATS_EN
    logic [15:0] symbol_count_q, symbol_count_d;
    logic [15:0] error_count_q, error_count_d;

    // Saturating symbol / error counters, cleared while idle
    always_comb begin
        symbol_count_d = symbol_count_q;
        error_count_d  = error_count_q;
        if (phase_idle) begin
            symbol_count_d = '0;
            error_count_d  = '0;
        end else if (phase_decide) begin
            if (symbol_count_q != 16'hFFFF) begin
                symbol_count_d = symbol_count_q + 16'd1;
            end
            if (symbol_error_d && (error_count_q != 16'hFFFF)) begin
                error_count_d = error_count_q + 16'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            symbol_count_q <= '0;
            error_count_q  <= '0;
        end else begin
            symbol_count_q <= symbol_count_d;
            error_count_q  <= error_count_d;
        end
    end

    assign symbol_count = symbol_count_q;
    assign error_count  = error_count_q;
`else
    // Statistics counters are not present in this build.
`endif

endmodule
`default_nettype wire

// File: doc/fsk_symbol_decoder.md
# fsk_symbol_decoder

Consumer of the frequency analyzer's per-window tone counts. Drives the analyzer's `enable`/`clear` to cut the input into fixed symbol windows, then compares `f1_value` against `f2_value` at each window end to decide one FSK bit. Bits are assembled into `DATA_WIDTH`-bit words and presented on a valid/ready output. Sits directly downstream of `frequency_analyzer`, whose `f1_value`/`f2_value` ports it reads.

## Interface
- `CLOCK`, 50000000: system clock in Hz; must equal the analyzer's `CLOCK`.
- `BAUD_RATE`, 1000: symbols per second. Derived `WINDOW = CLOCK/BAUD_RATE`, required ≥ 8.
- `MIN_COUNT`, 4: minimum winning count for a valid symbol.
- `DATA_WIDTH`, 8: bits per output word.

- `clock`, in, 1: system clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: decoder run. Low forces IDLE.
- `f1_value`, in, 32: analyzer count for FREQUENCY_1 (bit 0).
- `f2_value`, in, 32: analyzer count for FREQUENCY_2 (bit 1).
- `analyzer_enable`, out, 1: to analyzer `enable`.
- `analyzer_clear`, out, 1: to analyzer `clear`.
- `data_out`, out, DATA_WIDTH: assembled word, LSB = first received bit.
- `data_valid`, out, 1: `data_out` holds an unconsumed word.
- `data_ready`, in, 1: consumer accepts the word when high with `data_valid`.
- `symbol_error`, out, 1: one-cycle pulse on an undecidable symbol.
- `overrun`, out, 1: sticky; a word was dropped.

## Operation
- States: IDLE, CLEAR, ACCUM, SAMPLE, DECIDE.
- IDLE:
  - `analyzer_enable=0`, `analyzer_clear=0`.
  - Bit counter and shift register are zeroed; `overrun` is cleared.
  - Moves to CLEAR on the first cycle `enable=1`.
- CLEAR: 1 cycle. `analyzer_clear=1`, `analyzer_enable=0`.
- ACCUM: `WINDOW-3` cycles. `analyzer_enable=1`.
- SAMPLE: 1 cycle. `analyzer_enable=0`; `f1_value`/`f2_value` are captured into internal registers.
- DECIDE: 1 cycle. Acts on the captured values, then goes to CLEAR (or IDLE if `enable=0`).
  - Bit 1 when f2 > f1 and f2 ≥ MIN_COUNT.
  - Bit 0 when f1 > f2 and f1 ≥ MIN_COUNT.
  - Otherwise (equal counts, or winner below MIN_COUNT): `symbol_error` pulses, bit counter and shift register reset to 0, no bit is stored.
  - Comparisons are full 32-bit unsigned.
- Valid bit: shifted in at the MSB, shifting right, so that after DATA_WIDTH bits the first bit sits at `data_out[0]`.
- Completed word (bit counter reaches DATA_WIDTH, then wraps to 0):
  - If `data_valid=0`, or `data_valid=1` and `data_ready=1` in that same cycle: load `data_out`, set `data_valid=1`.
  - Else: drop the word and set `overrun=1`. `data_out` is unchanged.
- Handshake: `data_valid` stays high with `data_out` stable until a cycle with `data_ready=1`; it clears on the next edge unless a new word loads in that same cycle.
- `enable` low in any state: go to IDLE on the next edge; a partial word is discarded, and a pending `data_valid` word is kept.
- Symbol period is exactly WINDOW cycles.

## Timing
- Reset values: state IDLE; `analyzer_enable=0`, `analyzer_clear=0`, `data_out=0`, `data_valid=0`, `symbol_error=0`, `overrun=0`.
- All outputs are registered.
- `analyzer_clear` goes high 1 cycle after `enable` is first seen high.
- Word latency: `data_valid` rises 1 cycle after the DECIDE cycle of the last bit.
- Analyzer outputs must be stable 1 cycle after `analyzer_enable` falls; SAMPLE provides that cycle.
- `reset_n` asserted mid-window aborts immediately; no partial-word output.

## Configuration
- `FSK_DECODER_STATS_EN` defined: adds two 16-bit outputs.
  - `symbol_count`: increments on every DECIDE.
  - `error_count`: increments on every `symbol_error`.
  - Both saturate at 0xFFFF, reset to 0, and clear in IDLE.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package (`fsk_decoder_pkg`): state encoding constants, `WINDOW` derivation, minimum-window check.
- Sub-module `fsk_window_timer` (parameter `WINDOW`): generates the CLEAR/ACCUM/SAMPLE/DECIDE phase strobes. The top level holds the decision logic, shift register, output register and handshake.

## Test plan
All scenarios use CLOCK=1000, BAUD_RATE=100 (WINDOW=10, ACCUM=7), DATA_WIDTH=8, and a bench model driving `f1_value`/`f2_value` per window.
- Reset, then `enable=1` → `analyzer_clear` high exactly 1 cycle after enable; `analyzer_enable` high 7 cycles; pattern repeats every 10 cycles.
- 8 windows, bits 1,0,1,1,0,0,1,0 (winning count 9, loser 2), `data_ready=1` → `data_out=0x4D`, `data_valid` pulses for 1 cycle, 1 cycle after the 8th DECIDE.
- Window with f1=f2=6 after 3 valid bits → `symbol_error` pulses once; the next 8 valid bits yield one full word, with no stale bits.
- Winner count 3 (< MIN_COUNT 4) → `symbol_error`; no word.
- `data_ready=0` while two words complete → first word held stable, second dropped, `overrun=1` until `enable` drops.
- `reset_n` low during ACCUM of bit 5 → all outputs return to reset values asynchronously; no word emitted after release.
